// File: rtl/cnn_dot_pkg.sv
// Shared widths, saturation limits, controller state encoding and the
// output clamp used by the cnn_dot_seq dot-product sequencer.
package cnn_dot_pkg;

    localparam int X_W     = 14;
    localparam int W_W     = 6;
    localparam int P_W     = 20;
    localparam int OUT_W   = 14;
    localparam int SAT_MAX = 8191;
    localparam int SAT_MIN = -8192;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Clamp a wide signed value into the signed OUT_W output range.
    function automatic logic [OUT_W-1:0] sat_out(input logic signed [63:0] v);
        logic [OUT_W-1:0] r;
        if (v > 64'(SAT_MAX)) begin
            r = OUT_W'(SAT_MAX);
        end else if (v < 64'(SAT_MIN)) begin
            r = OUT_W'(SAT_MIN);
        end else begin
            r = v[OUT_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/cnn_dot_mul_14s_6s.sv
// Purely combinational signed 14x6 -> 20 multiplier; the caller registers
// the product so synthesis can pack it into a DSP slice.
module cnn_dot_mul_14s_6s
    import cnn_dot_pkg::*;
(
    input  logic signed [X_W-1:0] a_i,
    input  logic signed [W_W-1:0] b_i,
    output logic signed [P_W-1:0] p_o
);

    assign p_o = P_W'(a_i) * P_W'(b_i);

endmodule

// File: rtl/cnn_dot_seq.sv
// Convolution-window dot-product sequencer: streams pixel/weight pairs through
// one shared multiplier, accumulates, then biases, shifts and saturates.
module cnn_dot_seq
    import cnn_dot_pkg::*;
#(
    parameter int N_MAX  = 25,
    parameter int ADDR_W = 5,
    parameter int ACC_W  = 40
)
(
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [ADDR_W-1:0] len,
    input  logic [13:0]       bias,
    input  logic [3:0]        shift,
    output logic [ADDR_W-1:0] x_address0,
    output logic              x_ce0,
    input  logic [13:0]       x_q0,
    output logic [ADDR_W-1:0] w_address0,
    output logic              w_ce0,
    input  logic [5:0]        w_q0,
    output logic [13:0]       ap_return
);

    state_e                   state_q, state_d;
    logic [ADDR_W-1:0]        idx_q, idx_d;
    logic [ADDR_W-1:0]        lc_q, lc_d;
    logic [3:0]               shift_q, shift_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [P_W-1:0]    p_q;
    logic signed [P_W-1:0]    p_s;
    logic                     v0_q, v1_q;
    logic [OUT_W-1:0]         ret_q, ret_d;
    logic [ADDR_W-1:0]        len_c_s;

    cnn_dot_mul_14s_6s u_mul (
        .a_i (x_q0),
        .b_i (w_q0),
        .p_o (p_s)
    );

    assign len_c_s    = (len > ADDR_W'(N_MAX)) ? ADDR_W'(N_MAX) : len;
    assign x_address0 = idx_q;
    assign w_address0 = idx_q;
    assign x_ce0      = (state_q == S_RUN);
    assign w_ce0      = (state_q == S_RUN);
    assign ap_idle    = (state_q == S_IDLE);
    assign ap_done    = (state_q == S_DONE);
    assign ap_ready   = (state_q == S_DONE);
    assign ap_return  = ret_q;

    // Next-state, operand latching and accumulate logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lc_d    = lc_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        ret_d   = ret_q;
        if (v1_q) begin
            acc_d = acc_q + ACC_W'(p_q);
        end else begin
            acc_d = acc_q;
        end
        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    lc_d    = len_c_s;
                    shift_d = shift;
                    idx_d   = '0;
                    acc_d   = ACC_W'($signed(bias)) <<< shift;
                    state_d = (len_c_s == '0) ? S_DONE : S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (idx_q == lc_q - ADDR_W'(1)) begin
                    idx_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                // Stage-0 valid clear means only the final accumulate is left.
                if (!v0_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Result is captured with the final accumulator value so it is valid in DONE.
        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            ret_d = sat_out(64'(acc_d >>> shift_d));
        end else begin
            ret_d = ret_q;
        end
    end

    // State, pipeline and result registers with synchronous reset.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            lc_q    <= '0;
            shift_q <= 4'd0;
            acc_q   <= '0;
            p_q     <= '0;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lc_q    <= lc_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            p_q     <= p_s;
            v0_q    <= (state_q == S_RUN);
            v1_q    <= v0_q;
            ret_q   <= ret_d;
        end
    end

endmodule

// File: tb/tb_cnn_dot_seq.sv
// Directed scoreboard bench for cnn_dot_seq: stimulus pushes expected
// results and done cycles; a negedge monitor pops and compares on ap_done.
module tb_cnn_dot_seq;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ap_start;
    logic        ap_done, ap_idle, ap_ready;
    logic [4:0]  len;
    logic [13:0] bias;
    logic [3:0]  shift;
    logic [4:0]  x_address0, w_address0;
    logic        x_ce0, w_ce0;
    logic [13:0] x_q0;
    logic [5:0]  w_q0;
    logic [13:0] ap_return;

    logic [13:0] x_mem [32];
    logic [5:0]  w_mem [32];

    typedef struct {
        int ret;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   rd_cnt = 0;
    int   rd_mod = 1;

    cnn_dot_seq dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .ap_start   (ap_start),
        .ap_done    (ap_done),
        .ap_idle    (ap_idle),
        .ap_ready   (ap_ready),
        .len        (len),
        .bias       (bias),
        .shift      (shift),
        .x_address0 (x_address0),
        .x_ce0      (x_ce0),
        .x_q0       (x_q0),
        .w_address0 (w_address0),
        .w_ce0      (w_ce0),
        .w_q0       (w_q0),
        .ap_return  (ap_return)
    );

    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) cyc <= cyc + 1;

    // Single-port buffer models with one-cycle read latency.
    always @(posedge ap_clk) begin
        if (x_ce0) x_q0 <= x_mem[x_address0];
        if (w_ce0) w_q0 <= w_mem[w_address0];
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: read-address sequence and done/result scoreboard.
    always @(negedge ap_clk) begin
        if (!ap_rst) begin
            if (x_ce0) begin
                chk("x_addr", int'(x_address0), rd_cnt % rd_mod);
                chk("w_addr", int'(w_address0), rd_cnt % rd_mod);
                rd_cnt++;
            end
            if (ap_done || ap_ready) begin
                chk("ready_eq_done", int'(ap_ready), int'(ap_done));
            end
            if (ap_done) begin
                chk("done_expected", int'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("ap_return", int'($signed(ap_return)), e.ret);
                    chk("done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic fill(input int xv, input int wv);
        for (int i = 0; i < 32; i++) begin
            x_mem[i] = 14'(xv);
            w_mem[i] = 6'(wv);
        end
    endtask

    // One start/done transaction; lc is the effective (clamped) length.
    task automatic run_op(input int n, input int b, input int sh, input int exp_ret, input int lc);
        int   s;
        int   busy;
        bit   seen;
        exp_t e;
        @(negedge ap_clk);
        chk("idle_before_start", int'(ap_idle), 1);
        len      = 5'(n);
        bias     = 14'(b);
        shift    = 4'(sh);
        ap_start = 1'b1;
        s        = cyc;
        rd_cnt   = 0;
        rd_mod   = (lc > 0) ? lc : 1;
        e.ret    = exp_ret;
        e.cyc    = s + ((lc == 0) ? 1 : lc + 3);
        q.push_back(e);
        @(negedge ap_clk);
        ap_start = 1'b0;
        len      = 5'd17;
        bias     = 14'h2aaa;
        shift    = 4'd9;
        busy     = 0;
        seen     = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            if (!ap_idle) busy++;
            if (ap_done) seen = 1'b1;
            else @(negedge ap_clk);
        end
        chk("done_seen", int'(seen), 1);
        chk("busy_cycles", busy, (lc == 0) ? 1 : lc + 3);
        chk("read_count", rd_cnt, lc);
    endtask

    initial begin
        int   s;
        int   dones;
        exp_t e;
        ap_rst   = 1'b1;
        ap_start = 1'b0;
        len      = 5'd0;
        bias     = 14'd0;
        shift    = 4'd0;
        fill(0, 0);
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        chk("rst_idle", int'(ap_idle), 1);
        chk("rst_done", int'(ap_done), 0);
        chk("rst_ready", int'(ap_ready), 0);
        chk("rst_x_ce", int'(x_ce0), 0);
        chk("rst_w_ce", int'(w_ce0), 0);
        chk("rst_x_addr", int'(x_address0), 0);
        chk("rst_w_addr", int'(w_address0), 0);
        chk("rst_return", int'(ap_return), 0);
        ap_rst = 1'b0;

        // Basic three-pair product, then result held while idle.
        fill(0, 0);
        x_mem[0] = 14'sd100; x_mem[1] = -14'sd200; x_mem[2] = 14'sd300;
        w_mem[0] = 6'sd2;    w_mem[1] = 6'sd3;     w_mem[2] = -6'sd1;
        run_op(3, 0, 0, -700, 3);
        repeat (3) @(negedge ap_clk);
        chk("return_held", int'($signed(ap_return)), -700);

        fill(0, 0); x_mem[0] = 14'sd4;  w_mem[0] = 6'sd1;
        run_op(1, 10, 2, 11, 1);
        fill(0, 0); x_mem[0] = -14'sd5; w_mem[0] = 6'sd1;
        run_op(1, 0, 1, -3, 1);

        fill(8191, 31);
        run_op(25, 0, 0, 8191, 25);
        fill(-8192, 31);
        run_op(25, 0, 0, -8192, 25);

        run_op(0, -7, 0, -7, 0);

        // Over-long request: entries past 24 would corrupt the sum if read.
        fill(1000, 31);
        for (int i = 0; i < 25; i++) begin
            x_mem[i] = 14'(i);
            w_mem[i] = 6'sd1;
        end
        run_op(31, 0, 0, 300, 25);

        // Start held high: back-to-back runs every 6 cycles.
        fill(0, 0);
        x_mem[0] = 14'sd7; x_mem[1] = -14'sd3;
        w_mem[0] = 6'sd5;  w_mem[1] = 6'sd2;
        @(negedge ap_clk);
        len = 5'd2; bias = 14'sd1; shift = 4'd0; ap_start = 1'b1;
        s = cyc; rd_cnt = 0; rd_mod = 2;
        for (int r = 0; r < 3; r++) begin
            e.ret = 30;
            e.cyc = s + 5 + 6 * r;
            q.push_back(e);
        end
        dones = 0;
        for (int k = 0; k < 40 && dones < 3; k++) begin
            @(negedge ap_clk);
            if (ap_done) dones++;
        end
        ap_start = 1'b0;
        chk("held_start_dones", dones, 3);
        chk("held_start_reads", rd_cnt, 6);
        repeat (2) @(negedge ap_clk);
        chk("held_start_idle", int'(ap_idle), 1);

        // Reset during a len=10 run aborts without a done.
        @(negedge ap_clk);
        len = 5'd10; bias = 14'd0; shift = 4'd0; ap_start = 1'b1;
        rd_cnt = 0; rd_mod = 10;
        @(negedge ap_clk);
        ap_start = 1'b0;
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        chk("abort_idle", int'(ap_idle), 1);
        chk("abort_x_ce", int'(x_ce0), 0);
        chk("abort_w_ce", int'(w_ce0), 0);
        chk("abort_return", int'(ap_return), 0);
        chk("abort_done", int'(ap_done), 0);
        ap_rst = 1'b0;
        repeat (15) @(negedge ap_clk);

        fill(0, 0);
        x_mem[0] = -14'sd100; x_mem[1] = 14'sd50;
        w_mem[0] = -6'sd31;   w_mem[1] = -6'sd32;
        run_op(2, -5, 3, 182, 2);

        repeat (3) @(negedge ap_clk);
        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
